// File: rtl/kc_ls1u_instr_mem_sync.sv
// KC_LS1u instruction memory with a clocked fetch port.
// Fetches use a req/ready handshake, have wait states, and return one valid pulse.
module kc_ls1u_instr_mem_sync #(
    parameter int unsigned        ADDR_W      = 24,
    parameter int unsigned        INSTR_W     = 16,
    parameter int unsigned        DEPTH       = 256,
    parameter int unsigned        WAIT_CYC    = 1,
    parameter logic [INSTR_W-1:0] FAULT_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               fetch_fault,
    output logic               fault_sticky,
    input  logic               fault_clr,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               prog_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic               accept;
    logic               enter_resp;
    logic [ADDR_W-1:0]  resp_addr;
    logic               resp_ok;
    logic [INSTR_W-1:0] resp_word;
    logic               prog_ok;
    logic               fetch_set;
    logic               prog_set;

    // Full-width compare: high address bits must never alias into the array.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    assign accept = fetch_req && fetch_ready;

    // With no wait states the array is read on the acceptance edge itself.
    always_comb begin
        enter_resp = 1'b0;
        resp_addr  = addr_q;
        if (accept && (WAIT_CYC == 0)) begin
            enter_resp = 1'b1;
            resp_addr  = fetch_addr;
        end else if ((state == S_WAIT) && (cnt == '0)) begin
            enter_resp = 1'b1;
        end
    end

    assign resp_ok   = in_range(resp_addr);
    assign resp_word = mem[resp_addr[IDX_W-1:0]];
    assign prog_ok   = in_range(prog_addr);
    assign fetch_set = enter_resp && !resp_ok;
    assign prog_set  = prog_we && !prog_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_ready <= 1'b1;
            instr_valid <= 1'b0;
            instr       <= '0;
            fetch_fault <= 1'b0;
            cnt         <= '0;
            addr_q      <= '0;
        end else begin
            instr_valid <= enter_resp;
            if (enter_resp) begin
                instr       <= resp_ok ? resp_word : FAULT_INSTR;
                fetch_fault <= !resp_ok;
            end
            unique case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        addr_q <= fetch_addr;
                        if (WAIT_CYC == 0) begin
                            state       <= S_RESP;
                            fetch_ready <= 1'b1;
                        end else begin
                            state       <= S_WAIT;
                            fetch_ready <= 1'b0;
                            cnt         <= 4'(WAIT_CYC - 1);
                        end
                    end else if (state == S_RESP) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state       <= S_RESP;
                        fetch_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    fetch_ready <= 1'b1;
                end
            endcase
        end
    end

    // A new fault outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_err     <= 1'b0;
            fault_sticky <= 1'b0;
        end else begin
            prog_err <= prog_set;
            if (fetch_set || prog_set) begin
                fault_sticky <= 1'b1;
            end else if (fault_clr) begin
                fault_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

endmodule

// File: tb/tb_kc_ls1u_instr_mem_sync.sv
// Scoreboard bench: three instances (WAIT_CYC 1, 0, 3) checked against
// an edge-counting reference model with a write history for read-before-write.
module tb_kc_ls1u_instr_mem_sync;

    typedef struct {
        logic [23:0] a;
        int          due;
    } fx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;

    logic        req    [3];
    logic [23:0] faddr  [3];
    logic        frdy   [3];
    logic        ival   [3];
    logic [15:0] ins    [3];
    logic        ffault [3];
    logic        fstk   [3];
    logic        fclr   [3];
    logic        pwe    [3];
    logic [23:0] paddr  [3];
    logic [15:0] pdata  [3];
    logic        perr   [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h",
                     n, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        kc_ls1u_instr_mem_sync #(
            .ADDR_W(24), .INSTR_W(16), .DEPTH(256),
            .WAIT_CYC(WC), .FAULT_INSTR(16'h0000)
        ) dut (
            .clk(clk), .rst(rst),
            .fetch_req(req[g]), .fetch_addr(faddr[g]),
            .fetch_ready(frdy[g]), .instr_valid(ival[g]),
            .instr(ins[g]), .fetch_fault(ffault[g]),
            .fault_sticky(fstk[g]), .fault_clr(fclr[g]),
            .prog_we(pwe[g]), .prog_addr(paddr[g]),
            .prog_data(pdata[g]), .prog_err(perr[g])
        );

        logic [15:0] mem   [256];
        logic [15:0] prev  [256];
        int          wedge [256];
        fx_t         sb[$];
        int          next_ok = 0;
        bit          msticky = 0;
        bit          mperr = 0;
        logic [15:0] last_i = '0;
        logic        last_f = 1'b0;

        initial for (int i = 0; i < 256; i++) wedge[i] = -1;

        // Reference model: a fetch is taken when req is high and the
        // previous one started at least WC+1 edges earlier; it answers WC
        // edges after acceptance.
        always @(posedge clk or posedge rst) begin : model
            bit set;
            if (rst) begin
                sb.delete();
                next_ok = 0;
                msticky = 0;
                mperr   = 0;
            end else begin
                set = 0;
                if (req[g] && cyc >= next_ok) begin
                    sb.push_back('{faddr[g], cyc + WC});
                    next_ok = cyc + WC + 1;
                end
                foreach (sb[i])
                    if (sb[i].due == cyc && sb[i].a >= 24'd256) set = 1;
                mperr = pwe[g] && (paddr[g] >= 24'd256);
                if (mperr) begin
                    set = 1;
                end else if (pwe[g]) begin
                    prev[paddr[g][7:0]]  = mem[paddr[g][7:0]];
                    wedge[paddr[g][7:0]] = cyc;
                    mem[paddr[g][7:0]]   = pdata[g];
                end
                if (set) msticky = 1;
                else if (fclr[g]) msticky = 0;
            end
        end

        always @(negedge clk) begin : mon
            fx_t         it;
            int          e;
            logic [15:0] xi;
            logic        xf;
            if (rst) begin
                chk("rst_ready", g, frdy[g], 1);
                chk("rst_valid", g, ival[g], 0);
                chk("rst_instr", g, ins[g], 0);
                chk("rst_fault", g, ffault[g], 0);
                chk("rst_sticky", g, fstk[g], 0);
                chk("rst_prog_err", g, perr[g], 0);
                last_i = '0;
                last_f = 1'b0;
            end else begin
                e = cyc - 1;
                if (ival[g]) begin
                    if (sb.size() == 0) begin
                        chk("unexp_valid", g, ival[g], 0);
                    end else begin
                        it = sb.pop_front();
                        chk("latency", g, e, it.due);
                        if (it.a >= 24'd256) begin
                            xi = 16'h0000;
                            xf = 1'b1;
                        end else begin
                            xf = 1'b0;
                            xi = (wedge[it.a[7:0]] == e) ?
                                 prev[it.a[7:0]] : mem[it.a[7:0]];
                        end
                        chk("instr", g, ins[g], xi);
                        chk("fetch_fault", g, ffault[g], xf);
                        last_i = xi;
                        last_f = xf;
                    end
                end else begin
                    if (sb.size() > 0 && sb[0].due <= e) begin
                        chk("missing_valid", g, ival[g], 1);
                        void'(sb.pop_front());
                    end
                    chk("instr_hold", g, ins[g], last_i);
                    chk("fault_hold", g, ffault[g], last_f);
                end
                chk("ready", g, frdy[g], cyc >= next_ok);
                chk("sticky", g, fstk[g], msticky);
                chk("prog_err", g, perr[g], mperr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < 3; g++) begin
            req[g]  = 1'b0;
            fclr[g] = 1'b0;
            pwe[g]  = 1'b0;
        end
    endtask

    task automatic fetch(input int g, input logic [23:0] a);
        logic r;
        r = 1'b0;
        req[g]   = 1'b1;
        faddr[g] = a;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r = frdy[g];
            tick();
            if (r) return;
        end
        chk("accept_timeout", g, r, 1);
    endtask

    function automatic logic [15:0] init_word(input int g, input int a);
        logic [15:0] t0 [8];
        t0 = '{16'h30aa, 16'h31bb, 16'h32cc, 16'h33dd,
               16'h34ee, 16'h35ff, 16'h3611, 16'h3722};
        if (g == 0 && a < 8) return t0[a];
        if (g == 1 && a >= 8 && a <= 10) return 16'(16'h20ff + ((a - 8) << 8));
        if (a == 25) return 16'h1794;
        return 16'($urandom);
    endfunction

    function automatic logic [23:0] rand_addr();
        int s;
        s = $urandom % 8;
        if (s == 0) return 24'($urandom);
        if (s == 1) return 24'(256 + $urandom % 200);
        return 24'($urandom % 256);
    endfunction

    initial begin
        for (int g = 0; g < 3; g++) begin
            faddr[g] = '0;
            paddr[g] = '0;
            pdata[g] = '0;
        end
        idle_all();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int a = 0; a < 256; a++) begin
            for (int g = 0; g < 3; g++) begin
                pwe[g]   = 1'b1;
                paddr[g] = 24'(a);
                pdata[g] = init_word(g, a);
            end
            tick();
        end
        idle_all();
        tick();

        for (int a = 0; a < 8; a++) fetch(0, 24'(a));
        req[0] = 1'b0;
        repeat (4) tick();

        for (int a = 8; a < 11; a++) fetch(1, 24'(a));
        req[1] = 1'b0;
        repeat (3) tick();

        fetch(0, 24'd300);
        req[0] = 1'b0;
        repeat (3) tick();
        fetch(0, 24'h010005);
        req[0] = 1'b0;
        repeat (3) tick();
        fclr[0] = 1'b1;
        tick();
        fclr[0] = 1'b0;
        tick();

        pwe[0]   = 1'b1;
        paddr[0] = 24'h000100;
        pdata[0] = 16'hdead;
        tick();
        pwe[0] = 1'b0;
        repeat (2) tick();
        fetch(0, 24'd0);
        req[0] = 1'b0;
        repeat (3) tick();

        fetch(0, 24'd25);
        req[0]   = 1'b0;
        pwe[0]   = 1'b1;
        paddr[0] = 24'd25;
        pdata[0] = 16'h08ff;
        tick();
        pwe[0] = 1'b0;
        repeat (3) tick();
        fetch(0, 24'd25);
        req[0] = 1'b0;
        repeat (3) tick();

        fetch(2, 24'd5);
        req[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        fetch(2, 24'd5);
        req[2] = 1'b0;
        repeat (6) tick();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 400 == 0) begin
                idle_all();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                for (int g = 0; g < 3; g++) begin
                    req[g]   = ($urandom % 3) != 0;
                    faddr[g] = rand_addr();
                    pwe[g]   = ($urandom % 4) == 0;
                    paddr[g] = rand_addr();
                    pdata[g] = 16'($urandom);
                    fclr[g]  = ($urandom % 8) == 0;
                end
            end
            tick();
        end

        idle_all();
        repeat (8) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
